// File: rtl/sram_like_arbiter.sv
// N-channel SRAM-like arbiter with an in-order tag FIFO that routes data_ok/rdata back to the issuing channel.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); the default build is round-robin.
module sram_like_arbiter #(
  parameter int NUM_CH          = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [NUM_CH-1:0]              ch_req,
  input  logic [NUM_CH-1:0]              ch_wr,
  input  logic [2*NUM_CH-1:0]            ch_size,
  input  logic [NUM_CH*DATA_W/8-1:0]     ch_wstrb,
  input  logic [NUM_CH*ADDR_W-1:0]       ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]       ch_wdata,
  output logic [NUM_CH-1:0]              ch_addr_ok,
  output logic [NUM_CH-1:0]              ch_data_ok,
  output logic [DATA_W-1:0]              ch_rdata,
  output logic                           mem_req,
  output logic                           mem_wr,
  output logic [1:0]                     mem_size,
  output logic [DATA_W/8-1:0]            mem_wstrb,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic                           mem_addr_ok,
  input  logic                           mem_data_ok,
  input  logic [DATA_W-1:0]              mem_rdata,
  output logic [$clog2(MAX_OUTSTANDING):0] ost_cnt,
  output logic                           err_unexp
);

  localparam int CW = $clog2(NUM_CH);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int SW = DATA_W / 8;

  logic [ADDR_W-1:0] addr_a  [NUM_CH];
  logic [DATA_W-1:0] wdata_a [NUM_CH];
  logic [SW-1:0]     wstrb_a [NUM_CH];
  logic [1:0]        size_a  [NUM_CH];

  logic [CW-1:0] grant;
  logic [CW-1:0] grant_free;
  logic          lock_q, lock_d;
  logic [CW-1:0] lock_ch_q, lock_ch_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          err_q;
  logic          full, push, pop;
  logic [CW-1:0] head_tag;
  logic [CW-1:0] tag_mem [MAX_OUTSTANDING];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign addr_a[gi]  = ch_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_a[gi] = ch_wdata[gi*DATA_W +: DATA_W];
      assign wstrb_a[gi] = ch_wstrb[gi*SW +: SW];
      assign size_a[gi]  = ch_size[2*gi +: 2];
      assign ch_addr_ok[gi] = push & (grant == CW'(gi));
      assign ch_data_ok[gi] = pop & (head_tag == CW'(gi));
    end
  endgenerate

`ifdef SRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_free = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_req[i]) grant_free = CW'(i);
    end
  end
`else
  logic [CW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW:0]   rr_idx;
  logic          rr_found;

  // Scan from rr_ptr upward, wrapping, and take the first requester.
  always_comb begin
    grant_free = '0;
    rr_found   = 1'b0;
    rr_idx     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rr_idx = {1'b0, rr_ptr_q} + (CW+1)'(i);
      if (rr_idx >= (CW+1)'(NUM_CH)) rr_idx = rr_idx - (CW+1)'(NUM_CH);
      if (!rr_found && ch_req[rr_idx[CW-1:0]]) begin
        grant_free = rr_idx[CW-1:0];
        rr_found   = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) rr_ptr_d = (grant == CW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign grant   = lock_q ? lock_ch_q : grant_free;
  assign full    = (cnt_q == (PW+1)'(MAX_OUTSTANDING));
  assign mem_req = (|ch_req) & ~full;
  assign push    = mem_req & mem_addr_ok;
  assign pop     = mem_data_ok & (cnt_q != '0);
  assign head_tag = tag_mem[rd_ptr_q];
  assign ch_rdata = mem_rdata;
  assign ost_cnt  = cnt_q;
  assign err_unexp = err_q;

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mem_req && grant == CW'(i)) begin
        mem_wr    = ch_wr[i];
        mem_size  = size_a[i];
        mem_wstrb = wstrb_a[i];
        mem_addr  = addr_a[i];
        mem_wdata = wdata_a[i];
      end
    end
  end

  // A pending, unaccepted request pins the grant so its payload stays stable.
  always_comb begin
    lock_d    = mem_req & ~mem_addr_ok;
    lock_ch_d = lock_d ? grant : lock_ch_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
      cnt_q     <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (mem_data_ok && cnt_q == '0) err_q <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_q] <= grant;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter (NUM_CH=2, MAX_OUTSTANDING=4, round-robin build).
// Inputs change on the falling edge; combinational outputs are checked 1ns later.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  ch_req, ch_wr;
  logic [3:0]  ch_size;
  logic [7:0]  ch_wstrb;
  logic [63:0] ch_addr, ch_wdata;
  logic [1:0]  ch_addr_ok, ch_data_ok;
  logic [31:0] ch_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic [2:0]  ost_cnt;
  logic        err_unexp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .resetn(resetn),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_wstrb(ch_wstrb),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .ost_cnt(ost_cnt), .err_unexp(err_unexp)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    ch_req = '0; ch_wr = '0; ch_size = '0; ch_wstrb = '0;
    ch_addr = '0; ch_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    #1;
    chk("rst_ost", 64'(ost_cnt), 0);
    chk("rst_mem_req", 64'(mem_req), 0);
    chk("rst_addr_ok", 64'(ch_addr_ok), 0);
    chk("rst_data_ok", 64'(ch_data_ok), 0);
    chk("rst_err", 64'(err_unexp), 0);
    @(negedge clk);
    resetn = 1'b1;

    // Round-robin alternation with both channels requesting; ch1 is a write.
    ch_addr  = {32'h0000_0200, 32'h0000_0100};
    ch_wdata = {32'h0000_DEAD, 32'h0000_1111};
    ch_wstrb = {4'hF, 4'h3};
    ch_size  = {2'd2, 2'd1};
    ch_wr    = 2'b10;
    ch_req   = 2'b11;
    mem_addr_ok = 1'b1;
    #1;
    chk("rr0_addr_ok", 64'(ch_addr_ok), 2'b01);
    chk("rr0_addr", 64'(mem_addr), 32'h100);
    chk("rr0_wr", 64'(mem_wr), 0);
    chk("rr0_size", 64'(mem_size), 1);
    chk("rr0_wstrb", 64'(mem_wstrb), 4'h3);
    cyc();
    chk("rr_ost1", 64'(ost_cnt), 1);
    #1;
    chk("rr1_addr_ok", 64'(ch_addr_ok), 2'b10);
    chk("rr1_addr", 64'(mem_addr), 32'h200);
    chk("rr1_wr", 64'(mem_wr), 1);
    chk("rr1_wdata", 64'(mem_wdata), 32'hDEAD);
    chk("rr1_wstrb", 64'(mem_wstrb), 4'hF);
    cyc();
    #1;
    chk("rr2_addr_ok", 64'(ch_addr_ok), 2'b01);
    cyc();
    #1;
    chk("rr3_addr_ok", 64'(ch_addr_ok), 2'b10);
    cyc();
    chk("rr_ost4", 64'(ost_cnt), 4);
    #1;
    chk("full_mem_req", 64'(mem_req), 0);
    chk("full_addr_zero", 64'(mem_addr), 0);
    chk("full_addr_ok", 64'(ch_addr_ok), 0);

    ch_req = 2'b00; ch_wr = 2'b00; mem_addr_ok = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h50 + 32'(k);
      #1;
      chk($sformatf("rr_resp%0d_ok", k), 64'(ch_data_ok), (k % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("rr_resp%0d_rd", k), 64'(ch_rdata), 32'h50 + 32'(k));
      cyc();
    end
    mem_data_ok = 1'b0;
    chk("rr_drain_ost", 64'(ost_cnt), 0);
    chk("rr_drain_err", 64'(err_unexp), 0);

    // Lock: ch1 stalls for 3 cycles while ch0 joins; rr_ptr=0 would favour ch0.
    ch_addr = {32'h1c00_0010, 32'h0000_0100};
    ch_req  = 2'b10;
    #1;
    chk("lock0_addr", 64'(mem_addr), 32'h1c000010);
    chk("lock0_addr_ok", 64'(ch_addr_ok), 0);
    cyc();
    ch_req = 2'b11;
    for (int k = 1; k < 3; k++) begin
      #1;
      chk($sformatf("lock%0d_addr", k), 64'(mem_addr), 32'h1c000010);
      chk($sformatf("lock%0d_addr_ok", k), 64'(ch_addr_ok), 0);
      cyc();
    end
    mem_addr_ok = 1'b1;
    #1;
    chk("lock_hs_addr", 64'(mem_addr), 32'h1c000010);
    chk("lock_hs_addr_ok", 64'(ch_addr_ok), 2'b10);
    cyc();
    ch_req = 2'b01; mem_addr_ok = 1'b0;
    #1;
    chk("lock_after_addr", 64'(mem_addr), 32'h100);
    chk("lock_after_ok", 64'(ch_addr_ok), 0);
    cyc();
    chk("lock_ost", 64'(ost_cnt), 1);
    ch_req = 2'b00;
    mem_data_ok = 1'b1; mem_rdata = 32'h77;
    #1;
    chk("lock_resp_ok", 64'(ch_data_ok), 2'b10);
    cyc();
    mem_data_ok = 1'b0;
    chk("lock_drain_ost", 64'(ost_cnt), 0);

    // Four reads in order ch0,ch1,ch1,ch0, then pop while full plus push+pop.
    mem_addr_ok = 1'b1;
    ch_req = 2'b01; #1; chk("ord0_addr_ok", 64'(ch_addr_ok), 2'b01); cyc();
    ch_req = 2'b10; #1; chk("ord1_addr_ok", 64'(ch_addr_ok), 2'b10); cyc();
    ch_req = 2'b10; #1; chk("ord2_addr_ok", 64'(ch_addr_ok), 2'b10); cyc();
    ch_req = 2'b01; #1; chk("ord3_addr_ok", 64'(ch_addr_ok), 2'b01); cyc();
    chk("ord_ost4", 64'(ost_cnt), 4);
    mem_data_ok = 1'b1; mem_rdata = 32'hA;
    #1;
    chk("fullpop_mem_req", 64'(mem_req), 0);
    chk("fullpop_addr_ok", 64'(ch_addr_ok), 0);
    chk("fullpop_data_ok", 64'(ch_data_ok), 2'b01);
    chk("fullpop_rdata", 64'(ch_rdata), 32'hA);
    cyc();
    chk("fullpop_ost3", 64'(ost_cnt), 3);
    mem_rdata = 32'hB;
    #1;
    chk("pushpop_mem_req", 64'(mem_req), 1);
    chk("pushpop_addr_ok", 64'(ch_addr_ok), 2'b01);
    chk("pushpop_data_ok", 64'(ch_data_ok), 2'b10);
    chk("pushpop_rdata", 64'(ch_rdata), 32'hB);
    cyc();
    chk("pushpop_ost3", 64'(ost_cnt), 3);
    ch_req = 2'b00; mem_addr_ok = 1'b0;
    mem_rdata = 32'hC; #1; chk("ordC_data_ok", 64'(ch_data_ok), 2'b10); chk("ordC_rdata", 64'(ch_rdata), 32'hC); cyc();
    mem_rdata = 32'hD; #1; chk("ordD_data_ok", 64'(ch_data_ok), 2'b01); chk("ordD_rdata", 64'(ch_rdata), 32'hD); cyc();
    mem_rdata = 32'hE; #1; chk("ordE_data_ok", 64'(ch_data_ok), 2'b01); cyc();
    mem_data_ok = 1'b0;
    chk("ord_drain_ost", 64'(ost_cnt), 0);
    chk("ord_err", 64'(err_unexp), 0);

    // Unexpected response sets the sticky error; async reset clears it at once.
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    mem_data_ok = 1'b1; mem_rdata = 32'h99;
    #1;
    chk("unexp_data_ok", 64'(ch_data_ok), 0);
    chk("unexp_err_pre", 64'(err_unexp), 0);
    cyc();
    mem_data_ok = 1'b0;
    chk("unexp_err", 64'(err_unexp), 1);
    chk("unexp_ost", 64'(ost_cnt), 0);
    cyc();
    chk("unexp_sticky", 64'(err_unexp), 1);
    resetn = 1'b0;
    #1;
    chk("unexp_rst_err", 64'(err_unexp), 0);
    cyc();
    resetn = 1'b1;

    // Reset with three requests outstanding, then a normal transaction.
    ch_req = 2'b01; mem_addr_ok = 1'b1;
    cyc(); cyc(); cyc();
    chk("rst3_ost_pre", 64'(ost_cnt), 3);
    ch_req = 2'b00; mem_addr_ok = 1'b0;
    resetn = 1'b0;
    #1;
    chk("rst3_ost", 64'(ost_cnt), 0);
    chk("rst3_mem_req", 64'(mem_req), 0);
    cyc();
    resetn = 1'b1;
    ch_req = 2'b10; mem_addr_ok = 1'b1;
    #1;
    chk("post_addr_ok", 64'(ch_addr_ok), 2'b10);
    cyc();
    chk("post_ost1", 64'(ost_cnt), 1);
    ch_req = 2'b00; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h42;
    #1;
    chk("post_data_ok", 64'(ch_data_ok), 2'b10);
    chk("post_rdata", 64'(ch_rdata), 32'h42);
    cyc();
    mem_data_ok = 1'b0;
    chk("post_ost0", 64'(ost_cnt), 0);
    chk("post_err", 64'(err_unexp), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
